// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared definitions for the byte-stream program loader.
//   - frame command bytes
//   - loader FSM state encoding
//   - out-of-range helper for the 9-bit ADDR + item_index sum
package prog_loader_pkg;

  localparam logic [7:0] CMD_IMEM  = 8'h01;
  localparam logic [7:0] CMD_DMEM  = 8'h02;
  localparam logic [7:0] CMD_START = 8'h03;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    COUNT,
    PAYLOAD,
    RUN
  } loader_state_t;

  // True when a 9-bit target address falls outside a memory of 'depth' entries.
  function automatic logic addr_oob(input logic [8:0] addr, input logic [31:0] depth);
    return {23'b0, addr} >= depth;
  endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// word_assembler: builds a little-endian 32-bit word from four stream bytes.
//   clk_i, rst_i   clock / synchronous active-high reset
//   byte_i         incoming byte
//   byte_vld_i     byte is consumed this cycle (word payload only)
//   lane_i         byte lane 0..3 of the current word
//   word_o         assembled word; valid in the cycle word_done_o is high
//   word_done_o    combinational pulse on the 4th byte of a word
module word_assembler (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_vld_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  // Only the three earlier bytes need storage; the 4th byte is taken straight
  // from the input so the word is complete in the cycle it arrives.
  logic [23:0] shift_q, shift_d;

  always_comb begin
    shift_d = shift_q;
    if (byte_vld_i) shift_d = {byte_i, shift_q[23:8]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) shift_q <= '0;
    else       shift_q <= shift_d;
  end

  assign word_o      = {byte_i, shift_q};
  assign word_done_o = byte_vld_i && (lane_i == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream loader for instruction and data memories.
//   Frames: CMD ADDR COUNT payload. 0x01 = COUNT words into imem at word index
//   ADDR, 0x02 = COUNT bytes into dmem at byte ADDR, 0x03 = start CPU (single
//   byte). Out-of-range items are consumed but not written and set err_o.
// Ports:
//   clk_i, rst_i              clock / synchronous active-high reset
//   rx_data_i/valid_i/ready_o byte stream (accepted on valid && ready)
//   imem_we_o/addr_o/data_o   registered one-cycle instruction word write
//   dmem_we_o/addr_o/data_o   registered one-cycle data byte write
//   start_o                   sticky CPU start
//   busy_o                    frame in progress
//   err_o                     sticky error (bad command or address overflow)
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 32,
  parameter int IAW        = $clog2(IMEM_DEPTH),
  parameter int DAW        = $clog2(DMEM_DEPTH)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [7:0]     rx_data_i,
  input  logic           rx_valid_i,
  output logic           rx_ready_o,
  output logic           imem_we_o,
  output logic [IAW-1:0] imem_addr_o,
  output logic [31:0]    imem_data_o,
  output logic           dmem_we_o,
  output logic [DAW-1:0] dmem_addr_o,
  output logic [7:0]     dmem_data_o,
  output logic           start_o,
  output logic           busy_o,
  output logic           err_o
);

  loader_state_t  state_q, state_d;
  logic           is_imem_q, is_imem_d;
  logic [7:0]     addr_q, addr_d;
  logic [7:0]     count_q, count_d;
  logic [7:0]     item_q, item_d;
  logic [1:0]     lane_q, lane_d;

  logic           imem_we_q, imem_we_d;
  logic [IAW-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]    imem_data_q, imem_data_d;
  logic           dmem_we_q, dmem_we_d;
  logic [DAW-1:0] dmem_addr_q, dmem_addr_d;
  logic [7:0]     dmem_data_q, dmem_data_d;
  logic           start_q, start_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;

  logic           accept;
  logic           word_byte;
  logic           word_done;
  logic [31:0]    word;
  logic [8:0]     tgt_addr;
  logic           item_done;
  logic           item_last;

  assign rx_ready_o = !rst_i && (state_q != RUN);
  assign accept     = rx_valid_i && rx_ready_o;
  assign word_byte  = accept && (state_q == PAYLOAD) && is_imem_q;

  word_assembler u_asm (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .byte_i      (rx_data_i),
    .byte_vld_i  (word_byte),
    .lane_i      (lane_q),
    .word_o      (word),
    .word_done_o (word_done)
  );

  // 9-bit sum so ADDR near the top of an 8-bit range is detected, not wrapped.
  assign tgt_addr  = {1'b0, addr_q} + {1'b0, item_q};
  assign item_done = is_imem_q ? word_done : accept;
  assign item_last = (item_q == count_q - 8'd1);

  always_comb begin
    state_d     = state_q;
    is_imem_d   = is_imem_q;
    addr_d      = addr_q;
    count_d     = count_q;
    item_d      = item_q;
    lane_d      = lane_q;
    imem_we_d   = 1'b0;
    imem_addr_d = imem_addr_q;
    imem_data_d = imem_data_q;
    dmem_we_d   = 1'b0;
    dmem_addr_d = dmem_addr_q;
    dmem_data_d = dmem_data_q;
    start_d     = start_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (rx_data_i)
            CMD_IMEM: begin
              is_imem_d = 1'b1;
              state_d   = ADDR;
            end
            CMD_DMEM: begin
              is_imem_d = 1'b0;
              state_d   = ADDR;
            end
            CMD_START: begin
              start_d = 1'b1;
              state_d = RUN;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      ADDR: begin
        if (accept) begin
          addr_d  = rx_data_i;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (accept) begin
          count_d = rx_data_i;
          item_d  = '0;
          lane_d  = '0;
          state_d = (rx_data_i == 8'd0) ? IDLE : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (word_byte) lane_d = lane_q + 2'd1;
        if (item_done) begin
          if (is_imem_q) begin
            if (addr_oob(tgt_addr, 32'(IMEM_DEPTH))) begin
              err_d = 1'b1;
            end else begin
              imem_we_d   = 1'b1;
              imem_addr_d = tgt_addr[IAW-1:0];
              imem_data_d = word;
            end
          end else begin
            if (addr_oob(tgt_addr, 32'(DMEM_DEPTH))) begin
              err_d = 1'b1;
            end else begin
              dmem_we_d   = 1'b1;
              dmem_addr_d = tgt_addr[DAW-1:0];
              dmem_data_d = rx_data_i;
            end
          end
          item_d = item_q + 8'd1;
          if (item_last) state_d = IDLE;
        end
      end
      RUN: start_d = 1'b1;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ADDR) || (state_d == COUNT) || (state_d == PAYLOAD);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      is_imem_q   <= 1'b0;
      addr_q      <= '0;
      count_q     <= '0;
      item_q      <= '0;
      lane_q      <= '0;
      imem_we_q   <= 1'b0;
      imem_addr_q <= '0;
      imem_data_q <= '0;
      dmem_we_q   <= 1'b0;
      dmem_addr_q <= '0;
      dmem_data_q <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_imem_q   <= is_imem_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      item_q      <= item_d;
      lane_q      <= lane_d;
      imem_we_q   <= imem_we_d;
      imem_addr_q <= imem_addr_d;
      imem_data_q <= imem_data_d;
      dmem_we_q   <= dmem_we_d;
      dmem_addr_q <= dmem_addr_d;
      dmem_data_q <= dmem_data_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign imem_we_o   = imem_we_q;
  assign imem_addr_o = imem_addr_q;
  assign imem_data_o = imem_data_q;
  assign dmem_we_o   = dmem_we_q;
  assign dmem_addr_o = dmem_addr_q;
  assign dmem_data_o = dmem_data_q;
  assign start_o     = start_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader sitting in front of `CPU`. It writes instruction words into `Instruction_Memory` and bytes into `Data_Memory` from a framed valid/ready byte stream, then raises `start_i` to the CPU. It replaces hierarchical preloading with a synthesizable write path, so the same program image (for example the Fibonacci program with n = 5 at data 0x00) can be delivered by hardware.

## Interface
Parameters:
- `IMEM_DEPTH`, 256: instruction memory depth in 32-bit words.
- `DMEM_DEPTH`, 32: data memory depth in bytes.
- `IAW`, $clog2(IMEM_DEPTH): instruction word address width.
- `DAW`, $clog2(DMEM_DEPTH): data byte address width.

Ports:
- `clk_i`  in  1  clock; the only clock.
- `rst_i`  in  1  reset, synchronous and active-high.
- `rx_data_i`  in  8  stream byte.
- `rx_valid_i`  in  1  byte valid.
- `rx_ready_o`  out  1  byte accepted when valid && ready at a rising edge.
- `imem_we_o`  out  1  one-cycle instruction word write strobe.
- `imem_addr_o`  out  IAW  word index.
- `imem_data_o`  out  32  instruction word.
- `dmem_we_o`  out  1  one-cycle data byte write strobe.
- `dmem_addr_o`  out  DAW  byte address.
- `dmem_data_o`  out  8  data byte.
- `start_o`  out  1  drives CPU `start_i`; sticky until reset.
- `busy_o`  out  1  high while a frame is in progress (state ADDR, COUNT or PAYLOAD).
- `err_o`  out  1  sticky error flag.

## Operation
- Frame format: `CMD`, `ADDR`, `COUNT`, then the payload.
  - `CMD` 0x01 loads instruction words. `ADDR` is the word index. The payload is COUNT×4 bytes, each word little-endian (first byte = bits[7:0]).
  - `CMD` 0x02 loads data bytes. `ADDR` is the byte address. The payload is COUNT bytes.
  - `CMD` 0x03 starts the CPU. The frame is the single `CMD` byte; there is no ADDR, COUNT or payload.
- FSM states and transitions:
  - IDLE: 0x01 or 0x02 goes to ADDR. 0x03 goes to RUN. Any other byte is dropped, sets `err_o`, and the FSM stays in IDLE.
  - ADDR: latch the address, go to COUNT.
  - COUNT: latch the count. Count = 0 returns to IDLE with no writes; otherwise go to PAYLOAD.
  - PAYLOAD: a 2-bit byte lane counter is used for words.
    - Words are assembled in a 32-bit shift register.
    - On the 4th byte of a word (imem) or on every byte (dmem), issue a write at `ADDR + item_index`.
    - After item COUNT−1, return to IDLE.
  - RUN: `start_o` = 1 and `rx_ready_o` = 0 permanently; leave only via reset.
- Address arithmetic: `ADDR + item_index` is computed 9 bits wide.
  - If the result ≥ DEPTH, the write strobe is suppressed and `err_o` is set.
  - The payload is still consumed, so framing stays aligned. There is no wrap-around.
- `rx_ready_o` = !rst_i && state != RUN. Backpressure is therefore only present in RUN.
- Bytes with `rx_valid_i` = 0 are ignored. Gaps between bytes are allowed in any state.

## Timing
- Reset values of all registered outputs are 0: `imem_we_o`, `imem_addr_o`, `imem_data_o`, `dmem_we_o`, `dmem_addr_o`, `dmem_data_o`, `start_o`, `busy_o`, `err_o`. The state resets to IDLE. `rx_ready_o` is 0 while `rst_i` is high.
- Write strobes are registered.
  - `imem_we_o` is high for exactly one cycle, on the cycle after the 4th byte of a word is accepted. Address and data are valid in that same cycle.
  - `dmem_we_o` is high for exactly one cycle, on the cycle after its byte is accepted.
  - Back-to-back dmem bytes give back-to-back strobes.
- `start_o` rises on the cycle after 0x03 is accepted.
- Reset mid-frame discards the partial word and the latched ADDR/COUNT; no write is issued. Reset has priority over any byte accepted in the same cycle.
- Throughput: 1 byte/cycle sustained in all loading states.

## Structure
- Shared package `prog_loader_pkg`:
  - command constants `CMD_IMEM` = 8'h01, `CMD_DMEM` = 8'h02, `CMD_START` = 8'h03;
  - state enum `loader_state_t` {IDLE, ADDR, COUNT, PAYLOAD, RUN}.
- One natural sub-module, `word_assembler`: it takes bytes plus a lane counter and produces a 32-bit word plus a `word_done` pulse. The FSM, address adder and error logic stay in `prog_loader`.

## Test plan
- **Instruction load:** stream 01 00 02, then 13 00 00 00, then 93 00 10 00 → `imem_we_o` pulses twice, with (addr 0, 0x00000013) and (addr 1, 0x00100093), each one cycle after its 4th byte; `busy_o` falls after the last byte.
- **Data load then start:** stream 02 00 01 05, then 03 → `dmem_we_o` at addr 0 with 0x05; `start_o` = 1 the cycle after 0x03; `rx_ready_o` = 0 thereafter; further valid bytes produce no writes.
- **Overflow:** stream 02 1F 02 AA BB → write addr 31 = 0xAA; no write for the second byte; `err_o` = 1; the next frame 02 00 01 CC still writes addr 0 = 0xCC.
- **Bad command and zero count:** stream 7E → `err_o` = 1, FSM stays in IDLE; stream 01 04 00 → no writes, back in IDLE.
- **Reset mid-word:** stream 01 00 01 11 22, assert `rst_i` for 1 cycle, then stream 01 00 01 44 33 22 11 → exactly one `imem_we_o`, writing addr 0 = 0x11223344; `err_o` = 0 after reset.
- **Stalled stream:** stream the instruction-load scenario with `rx_valid_i` low on alternate cycles → identical writes, only delayed.
